// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the decode-stage register file.
//   XLEN    : default datapath width
//   REG_AW  : default register-id width
//   word_t / reg_id_t : default-width data and register-id types
//   pend_max(): saturation value of a pending-write counter of a given width
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] reg_id_t;

  function automatic int pend_max(input int pend_w);
    return (1 << pend_w) - 1;
  endfunction

endpackage

// File: rtl/pend_scoreboard.sv
// pend_scoreboard: per-register pending-write counters for RAW hazard tracking.
//   clk, rst     : clock, asynchronous active-high reset
//   issue_fire   : an accepted issue that must be counted (already gated by ready)
//   issue_rd     : destination of that issue
//   wb_en, wb_rd : writeback retiring one pending write on wb_rd
//   flush        : clears every counter; a same-cycle issue is dropped
//   eff          : effective pending count per register, packed r*PEND_W
//   sb_err       : sticky, writeback to a register with nothing pending
// Build option RF_SB_FORWARD_EN: when defined, a same-cycle writeback already
// lowers the effective count so the consumer can take the bypassed value.
module pend_scoreboard #(
  parameter int NREG     = 32,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_fire,
  input  logic [AW-1:0]          issue_rd,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_rd,
  input  logic                   flush,
  output logic [NREG*PEND_W-1:0] eff,
  output logic                   sb_err
);
  import cpu_pkg::*;

  localparam logic [PEND_W-1:0] PMAX = PEND_W'(pend_max(PEND_W));

  logic [PEND_W-1:0] pend [NREG];
  logic [NREG-1:0]   inc;
  logic [NREG-1:0]   dec;
  logic              err_hit;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc[r] = issue_fire && (issue_rd == AW'(r)) && !flush;
      dec[r] = wb_en && (wb_rd == AW'(r)) && (pend[r] != '0);
      // The hard-wired zero register is never tracked.
      if ((ZERO_REG != 0) && (r == 0)) begin
        inc[r] = 1'b0;
        dec[r] = 1'b0;
      end
    end
  end

  // A flush-cycle writeback is treated as legitimate (the issue it belongs
  // to was in flight), so it does not flag an error.
  assign err_hit = wb_en && !flush && (pend[wb_rd] == '0) &&
                   !((ZERO_REG != 0) && (wb_rd == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      if (err_hit) sb_err <= 1'b1;
      for (int r = 0; r < NREG; r++) begin
        if (flush)
          pend[r] <= '0;
        else if (inc[r] && !dec[r] && (pend[r] != PMAX))
          pend[r] <= pend[r] + 1'b1;
        else if (dec[r] && !inc[r])
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_eff
`ifdef RF_SB_FORWARD_EN
    assign eff[r*PEND_W +: PEND_W] = pend[r] - PEND_W'(dec[r]);
`else
    assign eff[r*PEND_W +: PEND_W] = pend[r];
`endif
  end

endmodule

// File: rtl/decode_rf_sb.sv
// decode_rf_sb: decode-stage register file with N read ports and a
// pending-write scoreboard that stalls RAW hazards.
//   clk, rst          : clock, asynchronous active-high reset
//   rs_id_i           : NRD read ids, port k at [k*AW +: AW]
//   rs_rdata_o        : NRD read data, port k at [k*XLEN +: XLEN]
//   hazard_o          : some read source still has an outstanding write
//   issue_valid_i/issue_rd_i/issue_ready_o : issue handshake (see below)
//   wb_en_i, wb_rd_i, wb_data_i : writeback write port
//   flush_i           : clears all pending counts, drops same-cycle issue
//   sb_err_o          : sticky, writeback with no pending write
//   regfile_dump_o    : registered contents for the co-sim harness
// Build option RF_SB_FORWARD_EN: enables writeback-to-read bypass and lets a
// same-cycle writeback resolve a hazard; undefined, reads see registers only.
//
// Handshake: an issue is accepted on a rising edge where issue_valid_i and
// issue_ready_o are both 1; ready is purely combinational from current state
// and inputs and does not depend on issue_valid_i.
module decode_rf_sb
  import cpu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int PEND_W   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rs_id_i,
  output logic [NRD*XLEN-1:0]  rs_rdata_o,
  output logic                 hazard_o,
  input  logic                 issue_valid_i,
  input  logic [AW-1:0]        issue_rd_i,
  output logic                 issue_ready_o,
  input  logic                 wb_en_i,
  input  logic [AW-1:0]        wb_rd_i,
  input  logic [XLEN-1:0]      wb_data_i,
  input  logic                 flush_i,
  output logic                 sb_err_o,
  output logic [NREG*XLEN-1:0] regfile_dump_o
);

  localparam logic [PEND_W-1:0] PMAX = PEND_W'(pend_max(PEND_W));

  logic [XLEN-1:0]        regs [NREG];
  logic [NREG*PEND_W-1:0] eff;
  logic [NRD-1:0]         port_haz;
  logic                   issue_zero;
  logic                   issue_fire;
  logic                   wb_write;

  assign wb_write = wb_en_i && !((ZERO_REG != 0) && (wb_rd_i == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wb_write) begin
      regs[wb_rd_i] <= wb_data_i;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] id;
    logic          is_zero;
    assign id      = rs_id_i[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (id == '0);
`ifdef RF_SB_FORWARD_EN
    assign rs_rdata_o[k*XLEN +: XLEN] = is_zero ? '0 :
                                        (wb_en_i && (wb_rd_i == id)) ? wb_data_i :
                                        regs[id];
`else
    assign rs_rdata_o[k*XLEN +: XLEN] = is_zero ? '0 : regs[id];
`endif
    assign port_haz[k] = !is_zero && (eff[id*PEND_W +: PEND_W] != '0);
  end

  assign hazard_o = |port_haz;

  // Issues to the zero register are accepted but never counted.
  assign issue_zero    = (ZERO_REG != 0) && (issue_rd_i == '0);
  assign issue_ready_o = !hazard_o &&
                         (issue_zero || (eff[issue_rd_i*PEND_W +: PEND_W] != PMAX));
  assign issue_fire    = issue_valid_i && issue_ready_o && !issue_zero;

  pend_scoreboard #(
    .NREG     (NREG),
    .PEND_W   (PEND_W),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_fire (issue_fire),
    .issue_rd   (issue_rd_i),
    .wb_en      (wb_en_i),
    .wb_rd      (wb_rd_i),
    .flush      (flush_i),
    .eff        (eff),
    .sb_err     (sb_err_o)
  );

  for (genvar r = 0; r < NREG; r++) begin : g_dump
    assign regfile_dump_o[r*XLEN +: XLEN] = regs[r];
  end

endmodule

// File: tb/tb_decode_rf_sb.sv
// tb_decode_rf_sb: directed bench for decode_rf_sb with a behavioural
// reference model (integer counters, plain register array).
module tb_decode_rf_sb;

`ifdef RF_SB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [9:0]    rs_id;
  logic [63:0]   rs_rdata;
  logic          hazard;
  logic          issue_valid;
  logic [4:0]    issue_rd;
  logic          issue_ready;
  logic          wb_en;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          flush;
  logic          sb_err;
  logic [1023:0] dump;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // reference model state
  int          m_pend [32];
  logic [31:0] m_regs [32];
  bit          m_err;
  logic [1023:0] exp_dump;

  decode_rf_sb dut (
    .clk            (clk),
    .rst            (rst),
    .rs_id_i        (rs_id),
    .rs_rdata_o     (rs_rdata),
    .hazard_o       (hazard),
    .issue_valid_i  (issue_valid),
    .issue_rd_i     (issue_rd),
    .issue_ready_o  (issue_ready),
    .wb_en_i        (wb_en),
    .wb_rd_i        (wb_rd),
    .wb_data_i      (wb_data),
    .flush_i        (flush),
    .sb_err_o       (sb_err),
    .regfile_dump_o (dump)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, actual=timeout required=done");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // model helpers
  function automatic int eff_m(input int r);
    int e;
    e = m_pend[r];
    if (FWD && wb_en && (int'(wb_rd) == r) && (e > 0)) e = e - 1;
    return e;
  endfunction

  function automatic bit exp_hazard();
    bit h;
    h = 1'b0;
    for (int k = 0; k < 2; k++)
      if (eff_m(int'(rs_id[k*5 +: 5])) != 0) h = 1'b1;
    return h;
  endfunction

  function automatic bit exp_ready();
    if (exp_hazard()) return 1'b0;
    if (issue_rd == 5'd0) return 1'b1;
    return eff_m(int'(issue_rd)) != 3;
  endfunction

  function automatic logic [31:0] exp_rd(input int k);
    int id;
    id = int'(rs_id[k*5 +: 5]);
    if (id == 0) return 32'h0;
    if (FWD && wb_en && (int'(wb_rd) == id)) return wb_data;
    return m_regs[id];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_pend[r] = 0;
        m_regs[r] = 32'h0;
      end
      m_err = 1'b0;
    end else begin
      bit acc;
      acc = issue_valid && exp_ready() && !flush && (issue_rd != 5'd0);
      if (flush) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
      end else begin
        if (wb_en && (wb_rd != 5'd0)) begin
          if (m_pend[wb_rd] > 0) m_pend[wb_rd] = m_pend[wb_rd] - 1;
          else m_err = 1'b1;
        end
        if (acc) m_pend[issue_rd] = m_pend[issue_rd] + 1;
      end
      if (wb_en && (wb_rd != 5'd0)) m_regs[wb_rd] = wb_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, outputs against the model
  always @(negedge clk) begin
    if (started) begin
      chk("m_rdata0", rs_rdata[31:0], exp_rd(0));
      chk("m_rdata1", rs_rdata[63:32], exp_rd(1));
      chk("m_hazard", {31'b0, hazard}, {31'b0, exp_hazard()});
      chk("m_ready", {31'b0, issue_ready}, {31'b0, exp_ready()});
      chk("m_sb_err", {31'b0, sb_err}, {31'b0, m_err});
      for (int r = 0; r < 32; r++) exp_dump[r*32 +: 32] = m_regs[r];
      checks++;
      if (dump !== exp_dump) begin
        errors++;
        $display("FAIL m_dump: actual=%h required=%h", dump, exp_dump);
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    wb_en       = 1'b0;
    wb_rd       = 5'd0;
    wb_data     = 32'h0;
    flush       = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = d;
  endtask

  initial begin
    idle();
    rs_id = 10'd0;
    #1 rst = 1'b1;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'b0, issue_ready}, 32'd1);
    chk("reset_hazard", {31'b0, hazard}, 32'd0);
    chk("reset_rdata0", rs_rdata[31:0], 32'h0);

    // bypass on x5
    cyc(); idle(); rs_id = {5'd0, 5'd5}; do_wb(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("bypass_same", rs_rdata[31:0], FWD ? 32'hDEADBEEF : 32'h0);
    cyc(); idle();
    @(negedge clk);
    chk("bypass_next", rs_rdata[31:0], 32'hDEADBEEF);
    chk("err_uncounted_wb", {31'b0, sb_err}, 32'd1);

    // reset mid-operation with a write pending on x6
    cyc(); idle(); do_issue(5'd6);
    cyc(); idle(); rs_id = {5'd6, 5'd5}; rst = 1'b1;
    @(negedge clk);
    chk("rst_rdata0", rs_rdata[31:0], 32'h0);
    chk("rst_hazard", {31'b0, hazard}, 32'd0);
    chk("rst_ready", {31'b0, issue_ready}, 32'd1);
    chk("rst_err", {31'b0, sb_err}, 32'd0);
    chk("rst_dump_x5", dump[5*32 +: 32], 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_hazard_x6", {31'b0, hazard}, 32'd0);

    // RAW stall on x7
    cyc(); idle(); rs_id = 10'd0; do_issue(5'd7);
    @(negedge clk);
    chk("raw_issue_ready", {31'b0, issue_ready}, 32'd1);
    cyc(); idle(); rs_id = {5'd0, 5'd7};
    @(negedge clk);
    chk("raw_hazard", {31'b0, hazard}, 32'd1);
    chk("raw_not_ready", {31'b0, issue_ready}, 32'd0);
    cyc(); idle(); do_wb(5'd7, 32'h12);
    @(negedge clk);
    chk("raw_wb_hazard", {31'b0, hazard}, FWD ? 32'd0 : 32'd1);
    chk("raw_wb_data", rs_rdata[31:0], FWD ? 32'h12 : 32'h0);
    cyc(); idle();
    @(negedge clk);
    chk("raw_after_hazard", {31'b0, hazard}, 32'd0);
    chk("raw_after_data", rs_rdata[31:0], 32'h12);

    // saturation on x3, reading x1/x2
    rs_id = {5'd2, 5'd1};
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); do_issue(5'd3);
      @(negedge clk);
      chk("sat_fill_ready", {31'b0, issue_ready}, 32'd1);
    end
    cyc(); idle(); do_issue(5'd3);
    @(negedge clk);
    chk("sat_full", {31'b0, issue_ready}, 32'd0);
    do_wb(5'd3, 32'h33);
    #1;
    chk("sat_wb_ready", {31'b0, issue_ready}, FWD ? 32'd1 : 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); idle();
      if (m_pend[3] != 0) do_wb(5'd3, 32'h300 + i);
    end
    cyc(); idle();

    // x0: issue and writeback ignored
    rs_id = {5'd0, 5'd0}; do_issue(5'd0);
    @(negedge clk);
    chk("x0_issue_ready", {31'b0, issue_ready}, 32'd1);
    cyc(); idle(); do_wb(5'd0, 32'hFF);
    @(negedge clk);
    chk("x0_wb_read", rs_rdata[31:0], 32'h0);
    chk("x0_wb_err", {31'b0, sb_err}, 32'd0);
    cyc(); idle();
    @(negedge clk);
    chk("x0_after_read", rs_rdata[31:0], 32'h0);
    chk("x0_after_hazard", {31'b0, hazard}, 32'd0);
    chk("x0_after_err", {31'b0, sb_err}, 32'd0);

    // flush with two writes pending on x4
    rs_id = {5'd2, 5'd1};
    cyc(); idle(); do_issue(5'd4);
    cyc(); idle(); do_issue(5'd4);
    cyc(); idle(); flush = 1'b1; do_issue(5'd4); do_wb(5'd10, 32'hAA);
    cyc(); idle(); rs_id = {5'd10, 5'd4};
    @(negedge clk);
    chk("flush_hazard", {31'b0, hazard}, 32'd0);
    chk("flush_ready", {31'b0, issue_ready}, 32'd1);
    chk("flush_err", {31'b0, sb_err}, 32'd0);
    chk("flush_wb_data", rs_rdata[63:32], 32'hAA);

    // underflow on x9 sets sticky error
    cyc(); idle(); do_wb(5'd9, 32'h99);
    cyc(); idle(); rs_id = {5'd0, 5'd9};
    @(negedge clk);
    chk("uf_err", {31'b0, sb_err}, 32'd1);
    chk("uf_data", rs_rdata[31:0], 32'h99);
    repeat (3) cyc();
    @(negedge clk);
    chk("uf_err_sticky", {31'b0, sb_err}, 32'd1);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
